// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared FSM state type and counter sizing for the bit-serial subtractor
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter width; never below 1 so the counter always exists.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - combinational one-bit full-subtractor cell
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A-B with registered borrow and optional cut-chain low bits
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW:0]   APPROX_LIM = (CW+1)'(APPROX_BITS);
  localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    cnt;
  logic             bin_q;

  logic approx;
  logic cell_bin;
  logic cell_d;
  logic cell_bout;
  logic bout_eff;

  // Low positions run the cell with no borrow in and drop its borrow out.
  assign approx   = ({1'b0, cnt} < APPROX_LIM);
  assign cell_bin = approx ? 1'b0 : bin_q;
  assign bout_eff = approx ? 1'b0 : cell_bout;

  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (cell_bin),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      cnt        <= '0;
      bin_q      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            cnt      <= '0;
            bin_q    <= 1'b0;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          diff  <= {cell_d, diff[WIDTH-1:1]};
          bin_q <= bout_eff;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            borrow_out <= bout_eff;
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          // Returning to IDLE here keeps a new accept at least one edge after consume.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench driving exact and APPROX_BITS=4 instances in lockstep
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic       in_ready0, out_valid0, borrow0;
  logic [7:0] diff0;
  logic       in_ready1, out_valid1, borrow1;
  logic [7:0] diff1;

  int n_assert = 0;
  int n_fail   = 0;

  logic [8:0] q_exact[$];
  logic [8:0] q_apx[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .APPROX_BITS(0)) dut_exact (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
    .diff(diff0), .borrow_out(borrow0)
  );

  serial_subtractor #(.WIDTH(8), .APPROX_BITS(4)) dut_apx (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
    .diff(diff1), .borrow_out(borrow1)
  );

  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input int k);
    logic [7:0] hx, hy, hd, m;
    if (k == 0) return {x < y, x - y};
    m  = 8'((9'h1 << k) - 9'h1);
    hx = x >> k;
    hy = y >> k;
    hd = hx - hy;
    return {hx < hy, ((x ^ y) & m) | 8'(hd << k)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input bit bp, input bit chk_lat);
    int lat;
    int w;
    logic [8:0] e0, e1;
    w = 0;
    while (!(in_ready0 && in_ready1) && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_accept", {31'b0, in_ready0 & in_ready1}, 32'd1);
    if (bp) out_ready = 1'b0;
    a = ta;
    b = tb;
    in_valid = 1'b1;
    q_exact.push_back(model(ta, tb, 0));
    q_apx.push_back(model(ta, tb, 4));
    @(negedge clk);
    in_valid = 1'b0;
    a = ~ta;
    b = ~tb;
    lat = 0;
    while (!out_valid0 && lat < 50) begin
      in_valid = bp && (lat == 3);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    if (chk_lat) check("latency", lat, 8);
    check("valid_pair", {31'b0, out_valid1}, {31'b0, out_valid0});
    e0 = q_exact.pop_front();
    e1 = q_apx.pop_front();
    check("exact_result", {23'b0, borrow0, diff0}, {23'b0, e0});
    check("apx_result", {23'b0, borrow1, diff1}, {23'b0, e1});
    if (bp) begin
      for (int k = 0; k < 5; k++) begin
        in_valid = (k == 2);
        @(negedge clk);
        check("bp_valid", {31'b0, out_valid0}, 32'd1);
        check("bp_hold", {23'b0, borrow0, diff0}, {23'b0, e0});
        check("bp_in_ready", {31'b0, in_ready0}, 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    if (chk_lat) begin
      check("consumed_valid", {31'b0, out_valid0 | out_valid1}, 32'd0);
      check("consumed_ready", {31'b0, in_ready0 & in_ready1}, 32'd1);
    end
  endtask

  initial begin
    int w;
    logic [7:0] ra, rb;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready0}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid0}, 32'd0);
    check("rst_diff", {24'b0, diff0}, 32'd0);
    check("rst_borrow", {31'b0, borrow0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h5A, 8'h23, 1'b0, 1'b1);
    run_op(8'h00, 8'h01, 1'b0, 1'b1);

    // in_valid held through consume must not be taken until the following edge
    a = 8'h10; b = 8'h20; in_valid = 1'b1;
    q_exact.push_back(model(8'h10, 8'h20, 0));
    q_apx.push_back(model(8'h10, 8'h20, 4));
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_accepted", {31'b0, in_ready0}, 32'd0);
    w = 0;
    while (!out_valid0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("b2b_latency", w, 8);
    check("b2b_exact", {23'b0, borrow0, diff0}, {23'b0, q_exact.pop_front()});
    check("b2b_apx", {23'b0, borrow1, diff1}, {23'b0, q_apx.pop_front()});
    in_valid = 1'b1;
    @(negedge clk);
    check("no_accept_on_consume", {31'b0, in_ready0}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);

    run_op(8'h10, 8'h01, 1'b0, 1'b1);
    check("approx_known", {24'b0, 8'h11}, {24'b0, model(8'h10, 8'h01, 4)});
    run_op(8'hFF, 8'hFF, 1'b1, 1'b1);

    // reset in the 4th SHIFT cycle discards the operation
    a = 8'h33; b = 8'h44; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'b0, in_ready0 & in_ready1}, 32'd1);
    check("mid_rst_out_valid", {31'b0, out_valid0 | out_valid1}, 32'd0);
    check("mid_rst_diff", {24'b0, diff0 | diff1}, 32'd0);
    check("mid_rst_borrow", {31'b0, borrow0 | borrow1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    w = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid0 || out_valid1) w++;
    end
    check("no_valid_after_rst", w, 0);
    run_op(8'h80, 8'h7F, 1'b0, 1'b1);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (n == 0) begin ra = 8'h00; rb = 8'hFF; end
      run_op(ra, rb, 1'b0, (n < 4));
    end

    check("queues_empty", q_exact.size() + q_apx.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
